// File: rtl/regfile_param.sv
// ============================================================================
// regfile_param - 2R/1W register file with hazard scoreboard and clear sweep;
// optional write-to-read forwarding under REGFILE_BYPASS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWr,
  input  logic [ADDR_W-1:0] rW,
  input  logic [DATA_W-1:0] busW,
  input  logic [ADDR_W-1:0] rS1,
  input  logic [ADDR_W-1:0] rS2,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              hazA,
  output logic              hazB,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_sb;
  logic [DEPTH-1:0]  w_sb_nxt;

  logic w_idle;
  logic w_wr_en;
  logic w_rsv_en;
  logic w_zero_a;
  logic w_zero_b;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_en  = w_idle && regWr     && !((ZERO_REG != 0) && (rW == '0));
  assign w_rsv_en = w_idle && rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));
  assign w_zero_a = (ZERO_REG != 0) && (rS1 == '0);
  assign w_zero_b = (ZERO_REG != 0) && (rS2 == '0);
  assign clr_busy = (r_state == S_SWEEP);

  // Clear sweep controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      S_SWEEP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Reservation is applied after the write clear so a same-address reserve wins
  always_comb begin
    w_sb_nxt = r_sb;
    if (r_state == S_SWEEP) begin
      w_sb_nxt[r_cnt] = 1'b0;
    end else begin
      if (w_wr_en)  w_sb_nxt[rW]       = 1'b0;
      if (w_rsv_en) w_sb_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == S_SWEEP) begin
      r_regs[r_cnt] <= '0;
    end else if (w_wr_en) begin
      r_regs[rW] <= busW;
    end
  end

  always_comb begin
    busA = w_zero_a ? '0   : r_regs[rS1];
    busB = w_zero_b ? '0   : r_regs[rS2];
    hazA = w_zero_a ? 1'b0 : r_sb[rS1];
    hazB = w_zero_b ? 1'b0 : r_sb[rS2];
`ifdef REGFILE_BYPASS_EN
    // w_wr_en already excludes the sweep and the hardwired zero register
    if (w_wr_en && (rW == rS1)) begin
      busA = busW;
      hazA = 1'b0;
    end
    if (w_wr_en && (rW == rS2)) begin
      busB = busW;
      hazB = 1'b0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// tb_regfile_param - scoreboard bench for regfile_param.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          regWr = 1'b0;
  logic [AW-1:0] rW = '0;
  logic [DW-1:0] busW = '0;
  logic [AW-1:0] rS1 = '0;
  logic [AW-1:0] rS2 = '0;
  logic [DW-1:0] busA;
  logic [DW-1:0] busB;
  logic          rsv_valid = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          hazA;
  logic          hazB;
  logic          clr_req = 1'b0;
  logic          clr_busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ha;
    logic          hb;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Reference model
  logic [DW-1:0] m_regs [DEPTH];
  logic          m_sb   [DEPTH];
  logic          m_busy;
  int            m_cnt;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .regWr(regWr), .rW(rW), .busW(busW),
    .rS1(rS1), .rS2(rS2), .busA(busA), .busB(busB),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .hazA(hazA), .hazB(hazB),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_sb[i]   = 1'b0;
    end
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // Apply the current inputs to the model, then advance one clock edge
  task automatic step();
    if (!m_busy) begin
      if (regWr && rW != 0) begin
        m_regs[rW] = busW;
        m_sb[rW]   = 1'b0;
      end
      if (rsv_valid && rsv_addr != 0) m_sb[rsv_addr] = 1'b1;
      if (clr_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      m_regs[m_cnt] = '0;
      m_sb[m_cnt]   = 1'b0;
      if (m_cnt == DEPTH - 1) m_busy = 1'b0;
      m_cnt = (m_cnt + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    exp_t x;
    x.a    = (rS1 == 0) ? '0 : m_regs[rS1];
    x.b    = (rS2 == 0) ? '0 : m_regs[rS2];
    x.ha   = (rS1 == 0) ? 1'b0 : m_sb[rS1];
    x.hb   = (rS2 == 0) ? 1'b0 : m_sb[rS2];
    x.busy = m_busy;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rS1 = 5'd5;
    rS2 = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    push_exp();
    e = exp_q.pop_front();
    n_checks++;
    if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
      n_fail++;
      $display("FAIL reset_held: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
               busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
    end
    rst_n = 1'b1;
    step();
    push_exp();
    e = exp_q.pop_front();
    n_checks++;
    if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
      n_fail++;
      $display("FAIL reset_release: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
               busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
    end
  endtask

  task automatic test_write();
    regWr = 1'b1; rW = 5'd7; busW = 32'hDEADBEEF;
    step();
    rW = 5'd0; busW = 32'h12345678;
    step();
    regWr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rS1 = (k == 0) ? 5'd7 : 5'd0;
      rS2 = (k == 0) ? 5'd0 : 5'd7;
      #1;
      push_exp();
      e = exp_q.pop_front();
      n_checks++;
      if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
        n_fail++;
        $display("FAIL write_r7_r0[%0d]: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
                 k, busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
      end
    end
  endtask

  task automatic test_reserve();
    string nm [5] = '{"rsv_r9", "wr_clears_r9", "same_edge_rsv_wins", "rsv_r0_noop", "split_rsv_wr"};
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin rsv_valid = 1'b1; rsv_addr = 5'd9; step(); rsv_valid = 1'b0;
                 step(); rS1 = 5'd9; rS2 = 5'd7; end
        1: begin regWr = 1'b1; rW = 5'd9; busW = 32'hA5A5A5A5; step(); regWr = 1'b0; end
        2: begin regWr = 1'b1; rW = 5'd9; busW = 32'h11111111;
                 rsv_valid = 1'b1; rsv_addr = 5'd9; step();
                 regWr = 1'b0; rsv_valid = 1'b0; end
        3: begin rsv_valid = 1'b1; rsv_addr = 5'd0; step(); rsv_valid = 1'b0;
                 rS2 = 5'd0; end
        default: begin regWr = 1'b1; rW = 5'd13; busW = 32'h00C0FFEE;
                 rsv_valid = 1'b1; rsv_addr = 5'd12; step();
                 regWr = 1'b0; rsv_valid = 1'b0; rS1 = 5'd12; rS2 = 5'd13; end
      endcase
      #1;
      push_exp();
      e = exp_q.pop_front();
      n_checks++;
      if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
        n_fail++;
        $display("FAIL %s: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
                 nm[k], busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
      end
    end
  endtask

  task automatic test_forward();
    exp_t x;
    regWr = 1'b1; rW = 5'd4; busW = 32'h77;
    step();
    regWr = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd4;
    step();
    rsv_valid = 1'b0;
    regWr = 1'b1; rW = 5'd4; busW = 32'h55; rS1 = 5'd4; rS2 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    x = '{a: 32'h55, b: 32'h55, ha: 1'b0, hb: 1'b0, busy: 1'b0};
`else
    x = '{a: 32'h77, b: 32'h77, ha: 1'b1, hb: 1'b1, busy: 1'b0};
`endif
    exp_q.push_back(x);
    e = exp_q.pop_front();
    n_checks++;
    if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
      n_fail++;
      $display("FAIL forward_pre_edge: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
               busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
    end
    step();
    regWr = 1'b0;
    #1;
    push_exp();
    e = exp_q.pop_front();
    n_checks++;
    if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
      n_fail++;
      $display("FAIL forward_post_edge: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
               busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
    end
  endtask

  task automatic test_sweep();
    int busy_cycles = 0;
    int bad = 0;
    regWr = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      rW = 5'(i); busW = 32'h1000 + 32'(i);
      step();
    end
    regWr = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd3;
    step();
    rsv_valid = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    // Mid-sweep traffic: write to r10 and a second clr_req must both be dropped
    for (int k = 0; k < 40; k++) begin
      if (!clr_busy) break;
      busy_cycles++;
      regWr = (k == 5); rW = 5'd10; busW = 32'hBAD0BAD0;
      clr_req = (k == 8);
      rS1 = 5'd10; rS2 = 5'd3;
      #1;
      push_exp();
      e = exp_q.pop_front();
      n_checks++;
      if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
        n_fail++;
        $display("FAIL sweep_cycle[%0d]: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
                 k, busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
      end
      step();
    end
    regWr = 1'b0; clr_req = 1'b0;
    n_checks++;
    if (busy_cycles != DEPTH) begin
      n_fail++;
      $display("FAIL sweep_duration: got %0d busy cycles, expected %0d", busy_cycles, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rS1 = 5'(i); rS2 = 5'(DEPTH - 1 - i);
      #1;
      push_exp();
      e = exp_q.pop_front();
      if ({busA, busB, hazA, hazB, clr_busy} !== e) bad++;
    end
    n_checks++;
    if (bad != 0 || e !== '0) begin
      n_fail++;
      $display("FAIL sweep_all_zero: got %0d nonzero entries, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_sweep();
    regWr = 1'b1; rW = 5'd20; busW = 32'hCAFEF00D;
    step();
    regWr = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd25;
    step();
    rsv_valid = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (12) step();
    rS1 = 5'd20; rS2 = 5'd25;
    #1;
    push_exp();
    e = exp_q.pop_front();
    n_checks++;
    if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
      n_fail++;
      $display("FAIL pre_reset_cycle12: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
               busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    push_exp();
    e = exp_q.pop_front();
    n_checks++;
    if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
      n_fail++;
      $display("FAIL async_reset: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
               busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
    end
    #1;
    rst_n = 1'b1;
    regWr = 1'b1; rW = 5'd6; busW = 32'h0000BEEF;
    step();
    regWr = 1'b0; rS1 = 5'd6; rS2 = 5'd20;
    #1;
    push_exp();
    e = exp_q.pop_front();
    n_checks++;
    if ({busA, busB, hazA, hazB, clr_busy} !== e) begin
      n_fail++;
      $display("FAIL idle_after_reset: got a=%h b=%h ha=%b hb=%b busy=%b, expected a=%h b=%h ha=%b hb=%b busy=%b",
               busA, busB, hazA, hazB, clr_busy, e.a, e.b, e.ha, e.hb, e.busy);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write();
    test_reserve();
    test_forward();
    test_sweep();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
